// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and helpers for the debounce bank
//
// Purpose: per-channel FSM state encoding and the counter-width helper used
// by every debounce channel.
// Ports: none (package).

package debounce_pkg;

  typedef enum logic [1:0] {
    SM_INIT    = 2'd0,
    SM_IDLE    = 2'd1,
    SM_HOLDOFF = 2'd2
  } dbc_state_t;

  // One counter serves both the debounce run length and the holdoff period,
  // so it must hold the larger of the two terminal values.
  function automatic int cnt_width(input int min_count, input int holdoff);
    int max_val;
    max_val = (min_count > holdoff) ? min_count : holdoff;
    if (max_val < 1) begin
      max_val = 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one synchronised, debounced input channel
//
// Purpose: synchronises one raw asynchronous input, captures its starting
// level, then tracks level changes that persist for G_MIN_COUNT samples,
// locking out further edges for G_HOLDOFF cycles after each change.
// Ports:
//   clk     - clock
//   aresetn - asynchronous active-low reset
//   en      - channel enable; low holds the channel in SM_INIT, outputs 0
//   din     - raw asynchronous input
//   dout    - debounced level
//   rise    - one-cycle pulse on a debounced 0->1 change
//   fall    - one-cycle pulse on a debounced 1->0 change
//   valid   - starting level has been captured

module debounce_channel
  import debounce_pkg::*;
#(
  parameter int G_SYNC_STAGES = 2,
  parameter int G_MIN_COUNT   = 16,
  parameter int G_HOLDOFF     = 256
) (
  input  logic clk,
  input  logic aresetn,
  input  logic en,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic valid
);

  localparam int CW = cnt_width(G_MIN_COUNT, G_HOLDOFF);
  localparam logic [CW-1:0] MIN_C   = CW'(G_MIN_COUNT);
  localparam logic [CW-1:0] HOLD_C  = CW'(G_HOLDOFF);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [G_SYNC_STAGES-1:0] sync_q;
  logic [G_SYNC_STAGES-1:0] prime_q;
  logic                     s;
  logic                     primed;

  dbc_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] run_len;
  logic          cand_q, cand_d;
  logic          dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  assign s = sync_q[G_SYNC_STAGES-1];

  // prime_q fills with ones behind the sync chain so the starting level is
  // only sampled once the chain holds real input rather than reset zeros.
  assign primed = prime_q[G_SYNC_STAGES-1];

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sync_q  <= '0;
      prime_q <= '0;
    end else begin
      sync_q  <= {sync_q[G_SYNC_STAGES-2:0], din};
      prime_q <= {prime_q[G_SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= SM_INIT;
      cnt_q   <= '0;
      cand_q  <= 1'b0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    run_len = '0;

    if (!en) begin
      state_d = SM_INIT;
      cnt_d   = '0;
      cand_d  = 1'b0;
      dout_d  = 1'b0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        SM_INIT: begin
          if (!primed) begin
            cnt_d = '0;
          end else begin
            // A zero count means no run is in progress, so this sample
            // starts a new run regardless of the stale candidate.
            if ((cnt_q == '0) || (s != cand_q)) begin
              run_len = CW'(1);
            end else begin
              run_len = cnt_inc;
            end
            cand_d = s;
            if (run_len >= MIN_C) begin
              dout_d  = s;
              valid_d = 1'b1;
              cnt_d   = '0;
              state_d = SM_IDLE;
            end else begin
              cnt_d = run_len;
            end
          end
        end

        SM_IDLE: begin
          if (s != dout_q) begin
            if (cnt_inc >= MIN_C) begin
              dout_d = s;
              rise_d = s;
              fall_d = ~s;
              cnt_d  = '0;
              if (G_HOLDOFF == 0) begin
                state_d = SM_IDLE;
              end else begin
                state_d = SM_HOLDOFF;
              end
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
        end

        SM_HOLDOFF: begin
          if (cnt_inc >= HOLD_C) begin
            cnt_d   = '0;
            state_d = SM_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        default: begin
          state_d = SM_INIT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign dout  = dout_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign valid = valid_q;

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - bank of independent debounced input channels
//
// Purpose: instantiates G_NUM_CHANNELS debounce_channel blocks; pure wiring.
// Ports:
//   clk            - clock for all channels
//   aresetn        - asynchronous active-low reset
//   chan_en        - per-channel enable
//   din_bounce     - raw asynchronous inputs
//   dout_debounced - debounced levels
//   rise_pulse     - one-cycle pulse per debounced 0->1 change
//   fall_pulse     - one-cycle pulse per debounced 1->0 change
//   valid          - per-channel starting level captured

module debounce_bank
  import debounce_pkg::*;
#(
  parameter int G_NUM_CHANNELS = 8,
  parameter int G_SYNC_STAGES  = 2,
  parameter int G_MIN_COUNT    = 16,
  parameter int G_HOLDOFF      = 256
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic [G_NUM_CHANNELS-1:0] chan_en,
  input  logic [G_NUM_CHANNELS-1:0] din_bounce,
  output logic [G_NUM_CHANNELS-1:0] dout_debounced,
  output logic [G_NUM_CHANNELS-1:0] rise_pulse,
  output logic [G_NUM_CHANNELS-1:0] fall_pulse,
  output logic [G_NUM_CHANNELS-1:0] valid
);

  for (genvar i = 0; i < G_NUM_CHANNELS; i++) begin : g_chan
    debounce_channel #(
      .G_SYNC_STAGES(G_SYNC_STAGES),
      .G_MIN_COUNT  (G_MIN_COUNT),
      .G_HOLDOFF    (G_HOLDOFF)
    ) u_chan (
      .clk    (clk),
      .aresetn(aresetn),
      .en     (chan_en[i]),
      .din    (din_bounce[i]),
      .dout   (dout_debounced[i]),
      .rise   (rise_pulse[i]),
      .fall   (fall_pulse[i]),
      .valid  (valid[i])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - self-checking bench for debounce_bank

module tb_debounce_bank;

  localparam int N    = 4;
  localparam int S    = 2;
  localparam int MIN  = 4;
  localparam int H    = 8;
  localparam int HIST = 4096;

  logic         clk = 1'b0;
  logic         aresetn = 1'b0;
  logic [N-1:0] chan_en = '0;
  logic [N-1:0] din_bounce = '0;
  logic [N-1:0] dout_debounced;
  logic [N-1:0] rise_pulse;
  logic [N-1:0] fall_pulse;
  logic [N-1:0] valid;

  always #5 clk = ~clk;

  debounce_bank #(
    .G_NUM_CHANNELS(N),
    .G_SYNC_STAGES (S),
    .G_MIN_COUNT   (MIN),
    .G_HOLDOFF     (H)
  ) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .chan_en       (chan_en),
    .din_bounce    (din_bounce),
    .dout_debounced(dout_debounced),
    .rise_pulse    (rise_pulse),
    .fall_pulse    (fall_pulse),
    .valid         (valid)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Input values seen at each clock edge since the last reset release.
  logic [N-1:0] d_hist [HIST];
  logic [N-1:0] e_hist [HIST];

  // Reference model: phase 0 capture, 1 tracking, 2 lockout; st is the first
  // edge whose sample belongs to the current phase.
  int           ph [N];
  int           st [N];
  logic [N-1:0] m_dout, m_valid, m_rise, m_fall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // True if every sample seen on edges k-MIN+1..k equals lvl.
  function automatic bit window_equal(input int ch, input int k, input logic lvl);
    for (int j = k - MIN + 1; j <= k; j++) begin
      if (d_hist[j-S][ch] !== lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    cyc = 0;
    m_dout = '0; m_valid = '0; m_rise = '0; m_fall = '0;
    for (int ch = 0; ch < N; ch++) begin
      ph[ch] = 0;
      st[ch] = 1;
    end
  endtask

  task automatic model_edge(input int k);
    logic smp;
    for (int ch = 0; ch < N; ch++) begin
      m_rise[ch] = 1'b0;
      m_fall[ch] = 1'b0;
      if (!e_hist[k][ch]) begin
        ph[ch] = 0; st[ch] = k + 1;
        m_dout[ch] = 1'b0; m_valid[ch] = 1'b0;
      end else if (k < S + 1) begin
        st[ch] = k + 1;
      end else begin
        smp = d_hist[k-S][ch];
        case (ph[ch])
          0: if ((k - st[ch] + 1 >= MIN) && window_equal(ch, k, smp)) begin
               m_dout[ch] = smp; m_valid[ch] = 1'b1;
               ph[ch] = 1; st[ch] = k + 1;
             end
          1: if ((smp != m_dout[ch]) && (k - st[ch] + 1 >= MIN) && window_equal(ch, k, smp)) begin
               m_rise[ch] = smp; m_fall[ch] = ~smp; m_dout[ch] = smp;
               ph[ch] = (H > 0) ? 2 : 1; st[ch] = k + 1;
             end
          default: if (k - st[ch] + 1 >= H) begin
               ph[ch] = 1; st[ch] = k + 1;
             end
        endcase
      end
    end
  endtask

  task automatic tick();
    if (cyc + 1 >= HIST) begin
      $display("FAIL hist_overflow at cycle %0d", cyc);
      $fatal(1, "history overflow");
    end
    d_hist[cyc+1] = din_bounce;
    e_hist[cyc+1] = chan_en;
    @(posedge clk);
    cyc++;
    #1;
    model_edge(cyc);
    check("dout",  dout_debounced, m_dout);
    check("valid", valid, m_valid);
    check("rise",  rise_pulse, m_rise);
    check("fall",  fall_pulse, m_fall);
    check("excl",  rise_pulse & fall_pulse, '0);
  endtask

  task automatic apply_reset(input logic [N-1:0] din_v, input logic [N-1:0] en_v);
    aresetn    = 1'b0;
    din_bounce = din_v;
    chan_en    = en_v;
    @(posedge clk); #1;
    @(posedge clk); #1;
    aresetn = 1'b1;
    model_reset();
  endtask

  initial begin
    int   t_fall;
    bit   found;
    logic pulses;
    bit   calm;

    // Start-up capture.
    apply_reset(4'b0101, 4'hF);
    repeat (5) tick();
    check("init_c5_valid", valid, 4'h0);
    tick();
    check("init_valid", valid, 4'hF);
    check("init_dout", dout_debounced, 4'b0101);
    check("init_pulse", rise_pulse | fall_pulse, 4'h0);

    // Bring channel 0 low and let it settle.
    din_bounce[0] = 1'b0;
    repeat (S + MIN + H + 2) tick();
    check("ch0_low", dout_debounced[0], 1'b0);

    // Clean rising step on channel 0.
    din_bounce[0] = 1'b1;
    repeat (5) tick();
    check("step_t5_dout", dout_debounced[0], 1'b0);
    tick();
    check("step_dout", dout_debounced[0], 1'b1);
    check("step_rise", rise_pulse[0], 1'b1);
    tick();
    check("step_rise_1cyc", rise_pulse[0], 1'b0);
    repeat (H) tick();

    // Channel 1 chatters every two cycles.
    pulses = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) din_bounce[1] = ~din_bounce[1];
      tick();
      pulses = pulses | rise_pulse[1] | fall_pulse[1];
    end
    check("chatter_dout", dout_debounced[1], 1'b0);
    check("chatter_pulse", pulses, 1'b0);

    // Channel 2 falls, then returns during holdoff.
    din_bounce[2] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (fall_pulse[2]) found = 1'b1;
    end
    check("fall2_seen", found, 1'b1);
    t_fall = cyc;
    repeat (3) tick();
    din_bounce[2] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (rise_pulse[2]) found = 1'b1;
    end
    check("rise2_seen", found, 1'b1);
    check("rise2_delay", cyc - t_fall, H + MIN);
    repeat (H) tick();

    // Channel 3 disabled mid-count, then re-enabled.
    din_bounce[3] = 1'b1;
    repeat (4) tick();
    chan_en[3] = 1'b0;
    tick();
    check("dis_dout", dout_debounced[3], 1'b0);
    check("dis_valid", valid[3], 1'b0);
    repeat (4) tick();
    check("dis_valid_hold", valid[3], 1'b0);
    chan_en[3] = 1'b1;
    pulses = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      pulses = pulses | rise_pulse[3] | fall_pulse[3];
      if (valid[3]) found = 1'b1;
    end
    check("reinit_valid", found, 1'b1);
    check("reinit_dout", dout_debounced[3], 1'b1);
    check("reinit_pulse", pulses, 1'b0);

    // Asynchronous reset while channel 0 is in holdoff.
    din_bounce[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (fall_pulse[0]) found = 1'b1;
    end
    check("fall0_seen", found, 1'b1);
    repeat (2) tick();
    aresetn = 1'b0;
    #2;
    check("arst_dout", dout_debounced, 4'h0);
    check("arst_valid", valid, 4'h0);
    check("arst_rise", rise_pulse, 4'h0);
    check("arst_fall", fall_pulse, 4'h0);

    // Randomised bounce with quiet stretches and occasional enable drops.
    for (int seg = 0; seg < 2; seg++) begin
      apply_reset(N'($urandom), 4'hF);
      for (int i = 0; i < 1500; i++) begin
        calm = ((i / 50) % 2) == 1;
        for (int ch = 0; ch < N; ch++) begin
          if ($urandom_range(0, calm ? 39 : 3) == 0) din_bounce[ch] = ~din_bounce[ch];
          if ($urandom_range(0, 199) == 0) chan_en[ch] = ~chan_en[ch];
        end
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 SHALL have parameter G_NUM_CHANNELS, default 8: number of independent input channels, range 1..32.
REQ-002 SHALL have parameter G_SYNC_STAGES, default 2: synchroniser flops per channel, range 2..4.
REQ-003 SHALL have parameter G_MIN_COUNT, default 16: consecutive differing samples required to change output, range 1..65535.
REQ-004 SHALL have parameter G_HOLDOFF, default 256: cycles edge detection is locked out after an output change, range 0..65535.
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port aresetn, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port chan_en, input, G_NUM_CHANNELS: per-channel enable, bit i gates channel i.
REQ-008 SHALL have port din_bounce, input, G_NUM_CHANNELS: raw asynchronous inputs.
REQ-009 SHALL have port dout_debounced, output, G_NUM_CHANNELS: debounced levels.
REQ-010 SHALL have port rise_pulse, output, G_NUM_CHANNELS: one-cycle pulse on each debounced 0->1 change.
REQ-011 SHALL have port fall_pulse, output, G_NUM_CHANNELS: one-cycle pulse on each debounced 1->0 change.
REQ-012 SHALL have port valid, output, G_NUM_CHANNELS: bit i high once channel i has captured its starting state.

Function
REQ-013 Each channel SHALL pass din_bounce[i] through G_SYNC_STAGES flops; the last stage is sample s.
REQ-014 Each channel SHALL run its own FSM with states SM_INIT, SM_IDLE, SM_HOLDOFF, plus one counter of width $clog2(max(G_MIN_COUNT,G_HOLDOFF)+1).
REQ-015 SM_INIT: counter counts consecutive equal s samples and clears on any change of s; on reaching G_MIN_COUNT, dout<=s, valid<=1, counter cleared, go SM_IDLE, no edge pulse.
REQ-016 SM_IDLE: counter increments each cycle s!=dout and clears when s==dout; the cycle it would reach G_MIN_COUNT, dout<=s, pulse asserted, counter cleared, go SM_HOLDOFF (or SM_IDLE directly if G_HOLDOFF=0).
REQ-017 Latency: a clean din step SHALL appear on dout exactly G_SYNC_STAGES+G_MIN_COUNT clock edges later; rise/fall pulse is coincident with the dout change and lasts one cycle.
REQ-018 SM_HOLDOFF: s ignored, counter counts G_HOLDOFF cycles, then clears and goes SM_IDLE; dout holds.
REQ-019 G_MIN_COUNT=1: dout SHALL follow the first differing sample with no additional delay.
REQ-020 Counters SHALL saturate, never wrap.
REQ-021 chan_en[i]=0 SHALL force channel i to SM_INIT with dout, valid, pulses and counter at 0 on the next edge; re-enabling restarts SM_INIT with no pulse.
REQ-022 Channels SHALL be fully independent; simultaneous events on multiple channels SHALL each be handled in the same cycle.
REQ-023 rise_pulse[i] and fall_pulse[i] SHALL never be high together.

Reset
REQ-024 aresetn low SHALL asynchronously clear all sync flops, counters, dout_debounced, rise_pulse, fall_pulse and valid to 0 and set every FSM to SM_INIT.
REQ-025 Reset deassertion mid-bounce SHALL be treated as a fresh start: SM_INIT, no pulse.

Structure
REQ-026 The state enum (SM_INIT, SM_IDLE, SM_HOLDOFF) and the counter-width function SHALL live in shared package debounce_pkg.
REQ-027 Per-channel logic SHALL be sub-module debounce_channel, instantiated G_NUM_CHANNELS times by a generate loop; debounce_bank adds no logic beyond wiring.

Verification (bench params: N=4, SYNC=2, MIN=4, HOLDOFF=8)
REQ-028 Reset release with din=4'b0101, en=4'hF -> valid=4'hF and dout=4'b0101 at cycle 6, no pulses.
REQ-029 Clean step din[0] 0->1 at cycle T -> dout[0]=1 and rise_pulse[0]=1 (one cycle) at T+6.
REQ-030 din[1] toggling every 2 cycles for 40 cycles -> dout[1] unchanged, no pulses.
REQ-031 din[2] step 1->0 then back to 1 three cycles after fall_pulse -> return ignored during holdoff; rise_pulse[2] exactly 4 cycles after holdoff ends.
REQ-032 chan_en[3] dropped mid-count, restored 5 cycles later with din[3]=1 -> dout[3]=0, valid[3]=0 while disabled; valid[3]=1 with no pulse after re-init.
REQ-033 aresetn asserted during holdoff of channel 0 -> all outputs 0 immediately, no clock needed.
